// File: rtl/jk_drv_pkg.sv
// Shared types and the JK excitation rule used by the excitation driver.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam int unsigned DC_SET_RESET = 0;
    localparam int unsigned DC_TOGGLE    = 1;

    // Returns {j, k} that moves one JK flip-flop from s to t.
    function automatic logic [1:0] excite(input logic s, input logic t, input int unsigned mode);
        logic [1:0] jk;
        jk = 2'b00;
        if (mode == DC_TOGGLE) begin
            jk = (s != t) ? 2'b11 : 2'b00;
        end else begin
            jk = {t & ~s, s & ~t};
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_target_fifo.sv
// Synchronous target FIFO; pointers wrap modulo DEPTH (power of two).
module jk_target_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Converts a stream of desired bank states into J/K commands for a JK flip-flop bank,
// tracking the expected bank state and flagging feedback mismatches.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DC_MODE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tgt_valid,
    input  logic [WIDTH-1:0]       tgt_data,
    output logic                   tgt_ready,
    input  logic                   step,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [WIDTH-1:0]       j,
    output logic [WIDTH-1:0]       k,
    output logic                   jk_valid,
    output logic                   err,
    input  logic                   clear_err,
    output logic [$clog2(DEPTH):0] level
);

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] next_j;
    logic [WIDTH-1:0] next_k;
    logic [1:0]       bit_jk;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             mismatch;

    assign tgt_ready = !fifo_full;
    assign push      = tgt_valid && tgt_ready;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign mismatch  = (state == CHECK) && (q_fb != shadow);

    jk_target_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (tgt_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Excitation from the tracked state to the FIFO head.
    always_comb begin
        next_j = '0;
        next_k = '0;
        bit_jk = 2'b00;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bit_jk    = excite(shadow[i], head[i], DC_MODE);
            next_j[i] = bit_jk[1];
            next_k[i] = bit_jk[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shadow   <= '0;
            target   <= '0;
            j        <= '0;
            k        <= '0;
            jk_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        j        <= next_j;
                        k        <= next_k;
                        target   <= head;
                        jk_valid <= 1'b1;
                        state    <= PRESENT;
                    end else begin
                        j        <= '0;
                        k        <= '0;
                        jk_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (step) begin
                        shadow   <= target;
                        j        <= '0;
                        k        <= '0;
                        jk_valid <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error; a detected mismatch takes priority over clear_err.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end else if (clear_err) begin
            err <= 1'b0;
        end
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Inverse of the JK flip-flop: converts a stream of desired register states into the per-bit J/K inputs that drive a WIDTH-bit bank of JK flip-flops to those states.
- Buffers targets in a small FIFO and tracks a shadow copy of the bank's current state.
- Presents J/K for one bank clock edge per target, then checks the bank's feedback against the expected state.
- Sits between a sequence source (valid/ready) and a bank of JK flip-flops.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- DEPTH, 4, target FIFO entries; power of 2, minimum 2.
- DC_MODE, 0, don't-care resolution. 0 = set/reset encoding; 1 = toggle-only encoding.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- tgt_valid  in  1  target word offered.
- tgt_data  in  WIDTH  desired next bank state.
- tgt_ready  out  1  FIFO can accept; equals !full.
- step  in  1  one-cycle pulse; the bank is clocked on this cycle's edge.
- q_fb  in  WIDTH  bank outputs, for checking.
- j  out  WIDTH  J inputs to the bank.
- k  out  WIDTH  K inputs to the bank.
- jk_valid  out  1  j/k hold a valid command; the bank may be stepped.
- err  out  1  sticky feedback-mismatch flag.
- clear_err  in  1  clears err.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, immediate) sets:
  - j=0, k=0, jk_valid=0, err=0, level=0, tgt_ready=1.
  - shadow=0, FSM=IDLE.
  - The bank also resets to 0.
- FIFO push: on tgt_valid && tgt_ready.
  - No bypass; the FIFO is not pushed while full.
  - Push and pop in the same cycle are both honoured; level is unchanged.
- Excitation per bit, from shadow s to target t:
  - DC_MODE=0: 0→0 J0K0; 0→1 J1K0; 1→0 J0K1; 1→1 J0K0.
  - DC_MODE=1: no change → J0K0; any change → J1K1.
- FSM IDLE:
  - If the FIFO is non-empty: pop, register j/k from (shadow, head), latch the target, set jk_valid=1, go PRESENT.
  - Otherwise j=k=0 and jk_valid=0.
  - Latency: a word pushed into an empty FIFO at edge n gives jk_valid=1 after edge n+1.
- FSM PRESENT:
  - Hold j/k and jk_valid while step=0.
  - On step=1: shadow<=target, j<=0, k<=0, jk_valid<=0, go CHECK.
- FSM CHECK (one cycle):
  - Compare q_fb to shadow; inequality sets err at the next edge.
  - Always return to IDLE.
  - Minimum spacing between bank steps is therefore 3 cycles.
- step outside PRESENT is ignored and has no effect.
- err is sticky. clear_err clears it; if a mismatch is detected in the same cycle as clear_err, set wins.
- Shadow is never corrected from q_fb; after an error the sequence continues from the expected state.
- Reset mid-operation: the FIFO is flushed, any pending target is discarded, and all outputs are zeroed.

Decomposition:
- Package jk_drv_pkg holds:
  - the FSM state enum (IDLE, PRESENT, CHECK);
  - DC_MODE encodings as constants;
  - a pure function excite(s, t, mode) returning {j, k} per bit.
- One sub-module: jk_target_fifo.
  - Synchronous FIFO, WIDTH×DEPTH, asynchronous reset.
  - Outputs full, empty, level.
  - Pointers wrap modulo DEPTH.
- The top level holds the FSM, the shadow register and the checker.

Test Plan:
- Reset check → j=0000, k=0000, jk_valid=0, tgt_ready=1, err=0, level=0. Apply step pulses while idle → shadow stays 0000.
- DC_MODE=0, push 1010 → after one edge j=1010, k=0000, jk_valid=1. Step with q_fb=1010 → err=0. Push 0110 → j=0100, k=1000.
- DC_MODE=1, same sequence → first j=k=1010, then j=k=1100. Step holds as above.
- DEPTH=4, no steps, push 6 words 0001..0110:
  - 0001 is popped into PRESENT;
  - after the 5th push, level=4 and tgt_ready=0;
  - the 6th push stalls;
  - one step and CHECK → pop → tgt_ready=1, and the 6th word is accepted.
- Push 1010, step with q_fb=1011 → err=1 two edges after step and stays 1. Pulse clear_err → err=0. Repeat with clear_err coinciding with the detect cycle → err=1.
- Push 1111, then assert reset while in PRESENT → j, k and jk_valid drop to 0 without a clock edge. After release, level=0, and pushing 0001 gives j=0001, k=0000, confirming shadow=0000.
